// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand widths, operand-sequencer states and opcode encodings.
package alu_pkg;

    localparam int unsigned ALU_W   = 4;
    localparam int unsigned ALU_OPW = 3;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OP  = 2'd2,
        S_RUN = 2'd3
    } seq_state_t;

    localparam logic [ALU_OPW-1:0] OP_ADD = 3'b000;
    localparam logic [ALU_OPW-1:0] OP_SUB = 3'b001;
    localparam logic [ALU_OPW-1:0] OP_NOT = 3'b010;
    localparam logic [ALU_OPW-1:0] OP_AND = 3'b011;
    localparam logic [ALU_OPW-1:0] OP_OR  = 3'b100;
    localparam logic [ALU_OPW-1:0] OP_XOR = 3'b101;
    localparam logic [ALU_OPW-1:0] OP_LT  = 3'b110;
    localparam logic [ALU_OPW-1:0] OP_EQ  = 3'b111;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, one-cycle press pulse.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic press_o
);

    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                // Only a rising stable level is a press; releases are silent.
                press_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/alu_operand_seq.sv
// Sequential operand entry for the board ALU: A, B, then opcode, committed together with a strobe.
module alu_operand_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH     = ALU_W,
    parameter int unsigned OPW       = ALU_OPW,
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_step,
    input  logic             btn_clr,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [OPW-1:0]   op_o,
    output logic             valid_o,
    output logic [1:0]       stage_o
);

    logic [WIDTH-1:0] sw_sync1_q, sw_sync2_q;
    logic             step, clr;
    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_b_q;
    logic [OPW-1:0]   sh_op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [OPW-1:0]   op_q;
    logic             valid_q;
    logic             do_step;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (btn_step),
        .press_o(step)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (btn_clr),
        .press_o(clr)
    );

    // Clear has priority over a coincident step.
    assign do_step = step && !clr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = S_A;
        end else if (step) begin
            unique case (state_q)
                S_A:     state_d = S_B;
                S_B:     state_d = S_OP;
                S_OP:    state_d = S_RUN;
                S_RUN:   state_d = S_A;
                default: state_d = S_A;
            endcase
        end
    end

    always_comb begin
        stage_o = state_q;
        a_o     = a_q;
        b_o     = b_q;
        op_o    = op_q;
        valid_o = valid_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
            sh_a_q     <= '0;
            sh_b_q     <= '0;
            sh_op_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            valid_q    <= 1'b0;
        end else begin
            sw_sync1_q <= sw;
            sw_sync2_q <= sw_sync1_q;
            valid_q    <= do_step && (state_q == S_OP);
            if (clr) begin
                sh_a_q  <= '0;
                sh_b_q  <= '0;
                sh_op_q <= '0;
            end else if (do_step) begin
                unique case (state_q)
                    S_A: sh_a_q <= sw_sync2_q;
                    S_B: sh_b_q <= sw_sync2_q;
                    S_OP: begin
                        sh_op_q <= sw_sync2_q[OPW-1:0];
                        a_q     <= sh_a_q;
                        b_q     <= sh_b_q;
                        op_q    <= sw_sync2_q[OPW-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_seq.sv
// Directed self-checking bench for alu_operand_seq with DB_CYCLES=16.
module tb_alu_operand_seq;

    localparam int unsigned DB   = 16;
    localparam int unsigned HOLD = DB + 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       btn_step, btn_clr;
    logic [3:0] a_o, b_o;
    logic [2:0] op_o;
    logic       valid_o;
    logic [1:0] stage_o;

    int n_tests = 0;
    int n_fail  = 0;
    int valid_cnt = 0;
    int v0;

    alu_operand_seq #(.WIDTH(4), .OPW(3), .DB_CYCLES(DB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw      (sw),
        .btn_step(btn_step),
        .btn_clr (btn_clr),
        .a_o     (a_o),
        .b_o     (b_o),
        .op_o    (op_o),
        .valid_o (valid_o),
        .stage_o (stage_o)
    );

    always #5 clk = ~clk;

    // Cycles with valid high, sampled mid-cycle.
    always @(negedge clk) if (valid_o === 1'b1) valid_cnt <= valid_cnt + 1;

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish, expected finish within 500000 time units");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_step(input logic [3:0] val);
        sw = val;
        cycles(4);
        btn_step = 1'b1;
        cycles(HOLD);
        btn_step = 1'b0;
        cycles(HOLD);
    endtask

    task automatic press_clr();
        btn_clr = 1'b1;
        cycles(HOLD);
        btn_clr = 1'b0;
        cycles(HOLD);
    endtask

    initial begin
        rst_n = 1'b0; sw = 4'h0; btn_step = 1'b0; btn_clr = 1'b0;
        cycles(3);
        chk("rst_a", 8'(a_o), 8'h0);
        chk("rst_b", 8'(b_o), 8'h0);
        chk("rst_op", 8'(op_o), 8'h0);
        chk("rst_valid", 8'(valid_o), 8'h0);
        chk("rst_stage", 8'(stage_o), 8'h0);
        rst_n = 1'b1;
        cycles(2);

        // 1: clean entry of 3, 5, ADD
        press_step(4'b0011);
        chk("t1_stage_b", 8'(stage_o), 8'h1);
        press_step(4'b0101);
        chk("t1_stage_op", 8'(stage_o), 8'h2);
        chk("t1_a_not_yet", 8'(a_o), 8'h0);
        chk("t1_valid_none", 8'(valid_cnt), 8'h0);
        press_step(4'b0000);
        chk("t1_a", 8'(a_o), 8'h3);
        chk("t1_b", 8'(b_o), 8'h5);
        chk("t1_op", 8'(op_o), 8'h0);
        chk("t1_stage_run", 8'(stage_o), 8'h3);
        chk("t1_valid_once", 8'(valid_cnt), 8'h1);

        // 2: bouncy press in S_RUN, then a steady hold
        for (int i = 0; i < 5; i++) begin
            btn_step = 1'b1; cycles(3);
            btn_step = 1'b0; cycles(3);
        end
        chk("t2_no_step_bounce", 8'(stage_o), 8'h3);
        btn_step = 1'b1;
        cycles(DB + 2);
        chk("t2_before_pulse", 8'(stage_o), 8'h3);
        cycles(1);
        chk("t2_after_pulse", 8'(stage_o), 8'h0);
        cycles(HOLD);
        btn_step = 1'b0;
        cycles(HOLD);
        chk("t2_single_step", 8'(stage_o), 8'h0);
        chk("t2_a_held", 8'(a_o), 8'h3);

        // 3: enter F, 8 then clear in S_OP
        press_step(4'b1111);
        press_step(4'b1000);
        chk("t3_stage_op", 8'(stage_o), 8'h2);
        press_clr();
        chk("t3_stage_clr", 8'(stage_o), 8'h0);
        chk("t3_a", 8'(a_o), 8'h3);
        chk("t3_b", 8'(b_o), 8'h5);
        chk("t3_op", 8'(op_o), 8'h0);
        chk("t3_sh_a", 8'(dut.sh_a_q), 8'h0);
        chk("t3_valid_none", 8'(valid_cnt), 8'h1);

        // 4: step and clr together
        press_step(4'b1001);
        chk("t4_stage_b", 8'(stage_o), 8'h1);
        chk("t4_sh_a_set", 8'(dut.sh_a_q), 8'h9);
        btn_step = 1'b1; btn_clr = 1'b1;
        cycles(HOLD);
        btn_step = 1'b0; btn_clr = 1'b0;
        cycles(HOLD);
        chk("t4_stage", 8'(stage_o), 8'h0);
        chk("t4_sh_a", 8'(dut.sh_a_q), 8'h0);
        chk("t4_sh_b", 8'(dut.sh_b_q), 8'h0);
        chk("t4_valid_none", 8'(valid_cnt), 8'h1);

        // 5: reset in S_OP while step is still held
        press_step(4'b0010);
        sw = 4'b0100; cycles(4);
        btn_step = 1'b1;
        cycles(HOLD);
        chk("t5_stage_op", 8'(stage_o), 8'h2);
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        chk("t5_a", 8'(a_o), 8'h0);
        chk("t5_b", 8'(b_o), 8'h0);
        chk("t5_op", 8'(op_o), 8'h0);
        chk("t5_stage", 8'(stage_o), 8'h0);
        chk("t5_valid", 8'(valid_o), 8'h0);
        cycles(5);
        btn_step = 1'b0;
        cycles(HOLD);
        chk("t5_no_step", 8'(stage_o), 8'h0);
        press_step(4'b0001);
        chk("t5_repress", 8'(stage_o), 8'h1);

        // 6: full cycle 7, 1, LT then step out of S_RUN
        press_clr();
        chk("t6_cleared", 8'(stage_o), 8'h0);
        v0 = valid_cnt;
        press_step(4'b0111);
        press_step(4'b0001);
        press_step(4'b0110);
        chk("t6_a", 8'(a_o), 8'h7);
        chk("t6_b", 8'(b_o), 8'h1);
        chk("t6_op", 8'(op_o), 8'h6);
        chk("t6_stage_run", 8'(stage_o), 8'h3);
        chk("t6_valid_once", 8'(valid_cnt - v0), 8'h1);
        press_step(4'b1111);
        chk("t6_stage_a", 8'(stage_o), 8'h0);
        chk("t6_a_held", 8'(a_o), 8'h7);
        chk("t6_b_held", 8'(b_o), 8'h1);
        chk("t6_op_held", 8'(op_o), 8'h6);

        // Upper switch bit ignored for the opcode
        press_step(4'b0000);
        press_step(4'b0000);
        press_step(4'b1101);
        chk("op_upper_ignored", 8'(op_o), 8'h5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
